// File: rtl/mem_arbiter_ctrl_if.sv
// Request, response and byte-wide RAM bundle for mem_arbiter_ctrl.
// The slave view is the controller; the master view is the requesters plus the RAM.
interface mem_arbiter_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_re;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;

    logic              ls_re;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [2:0]        ls_len;
    logic [31:0]       ls_wdata;
    logic [31:0]       ls_rdata;
    logic              ls_done;

    logic              mc_busy;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport master (
        output if_re, if_addr, ls_re, ls_we, ls_addr, ls_len, ls_wdata, ram_din,
        input  if_rdata, if_done, ls_rdata, ls_done, mc_busy, ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  if_re, if_addr, ls_re, ls_we, ls_addr, ls_len, ls_wdata, ram_din,
        output if_rdata, if_done, ls_rdata, ls_done, mc_busy, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Byte-wide RAM owner arbitrating fetch (port 1) and load/store (port 2) accesses.
// Define MC_RR_ARB_EN for round-robin tie breaking instead of fixed ls-over-if priority.
module mem_arbiter_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    mem_arbiter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    if (RAM_LAT != 1) begin : g_bad_ram_lat
        $error("mem_arbiter_ctrl supports RAM_LAT == 1 only");
    end

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [2:0]        len_reg;
    logic [3:0][7:0]   wdata_reg;
    logic              owner_ls_reg;
    logic              is_write_reg;
    logic [2:0]        issue_cnt_reg;
    logic [1:0]        cap_cnt_reg;
    logic              a_valid_reg;   // ram_a this cycle is a live read issue
    logic              d_valid_reg;   // ram_din this cycle belongs to byte cap_cnt_reg
    logic [ADDR_W-1:0] ram_a_reg;
    logic [7:0]        ram_dout_reg;
    logic              ram_wr_reg;
    logic [31:0]       if_hold_reg;
    logic [31:0]       ls_hold_reg;
    logic [31:0]       rbuf_word;

    logic              ls_req, grant_ls, start, req_write, last_capture;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_len, ls_len_eff;

`ifdef MC_RR_ARB_EN
    logic              last_ls_reg;
`endif

    always_comb begin
        ls_req = bus.ls_re | bus.ls_we;
`ifdef MC_RR_ARB_EN
        grant_ls = ls_req & ~(bus.if_re & last_ls_reg);
`else
        grant_ls = ls_req;
`endif
        start     = ls_req | bus.if_re;
        req_write = grant_ls & bus.ls_we;
        req_addr  = grant_ls ? bus.ls_addr : bus.if_addr;
        case (bus.ls_len)
            3'd1:    ls_len_eff = 3'd1;
            3'd2:    ls_len_eff = 3'd2;
            3'd3:    ls_len_eff = 3'd3;
            default: ls_len_eff = 3'd4;
        endcase
        req_len      = grant_ls ? ls_len_eff : 3'd4;
        last_capture = d_valid_reg && ({1'b0, cap_cnt_reg} == len_reg - 3'd1);

        state_next = state_reg;
        if (rdy_in) begin
            case (state_reg)
                IDLE:    if (start) state_next = req_write ? WRITE : READ;
                READ:    if (last_capture) state_next = DONE;
                WRITE:   if (issue_cnt_reg >= len_reg) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            len_reg       <= '0;
            wdata_reg     <= '0;
            owner_ls_reg  <= 1'b0;
            is_write_reg  <= 1'b0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            a_valid_reg   <= 1'b0;
            d_valid_reg   <= 1'b0;
            ram_a_reg     <= '0;
            ram_dout_reg  <= '0;
            ram_wr_reg    <= 1'b0;
            if_hold_reg   <= '0;
            ls_hold_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (rdy_in) begin
                case (state_reg)
                    IDLE: if (start) begin
                        addr_reg      <= req_addr;
                        len_reg       <= req_len;
                        wdata_reg     <= bus.ls_wdata;
                        owner_ls_reg  <= grant_ls;
                        is_write_reg  <= req_write;
                        ram_a_reg     <= req_addr;
                        issue_cnt_reg <= 3'd1;
                        cap_cnt_reg   <= '0;
                        a_valid_reg   <= ~req_write;
                        d_valid_reg   <= 1'b0;
                        ram_wr_reg    <= req_write;
                        if (req_write) ram_dout_reg <= bus.ls_wdata[7:0];
                    end
                    READ: begin
                        if (d_valid_reg) cap_cnt_reg <= cap_cnt_reg + 2'd1;
                        d_valid_reg <= a_valid_reg;
                        if (issue_cnt_reg < len_reg) begin
                            ram_a_reg     <= addr_reg + ADDR_W'(issue_cnt_reg);
                            issue_cnt_reg <= issue_cnt_reg + 3'd1;
                            a_valid_reg   <= 1'b1;
                        end else begin
                            a_valid_reg <= 1'b0;
                        end
                    end
                    WRITE: begin
                        if (issue_cnt_reg < len_reg) begin
                            ram_a_reg     <= addr_reg + ADDR_W'(issue_cnt_reg);
                            ram_dout_reg  <= wdata_reg[issue_cnt_reg[1:0]];
                            issue_cnt_reg <= issue_cnt_reg + 3'd1;
                        end else begin
                            ram_wr_reg <= 1'b0;
                        end
                    end
                    DONE: if (!is_write_reg) begin
                        if (owner_ls_reg) ls_hold_reg <= rbuf_word;
                        else              if_hold_reg <= rbuf_word;
                    end
                    default: ;
                endcase
            end else if (state_reg == READ) begin
                // In-flight bytes are dropped; issue resumes at the first uncaptured byte.
                issue_cnt_reg <= {1'b0, cap_cnt_reg};
                a_valid_reg   <= 1'b0;
                d_valid_reg   <= 1'b0;
            end
        end
    end

`ifdef MC_RR_ARB_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_ls_reg <= 1'b0;
        end else if (state_next == DONE && state_reg != DONE) begin
            last_ls_reg <= owner_ls_reg;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rbuf
            logic [7:0] byte_reg;
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    byte_reg <= '0;
                end else if (rdy_in && state_reg == IDLE && start) begin
                    byte_reg <= '0;
                end else if (rdy_in && state_reg == READ && d_valid_reg && cap_cnt_reg == 2'(gi)) begin
                    byte_reg <= bus.ram_din;
                end
            end
            assign rbuf_word[8*gi +: 8] = byte_reg;
        end
    endgenerate

    assign bus.if_done  = (state_reg == DONE) && !owner_ls_reg && rdy_in;
    assign bus.ls_done  = (state_reg == DONE) &&  owner_ls_reg && rdy_in;
    assign bus.if_rdata = (state_reg == DONE && !owner_ls_reg && !is_write_reg) ? rbuf_word : if_hold_reg;
    assign bus.ls_rdata = (state_reg == DONE &&  owner_ls_reg && !is_write_reg) ? rbuf_word : ls_hold_reg;
    assign bus.mc_busy  = (state_reg != IDLE);
    assign bus.ram_a    = ram_a_reg;
    assign bus.ram_dout = ram_dout_reg;
    assign bus.ram_wr   = ram_wr_reg & rdy_in;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a synchronous byte RAM model.
// Expected values are hand-derived from the access timing of each request.
module tb_mem_arbiter_ctrl;
`ifdef MC_RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   last_ls_m = 1'b0;

    logic [7:0] mem [1024];
    logic       pl_en = 1'b0;
    logic [9:0] pl_a  = '0;
    logic [7:0] pl_d  = '0;

    mem_arbiter_ctrl_if #(.ADDR_W(32)) bus ();

    mem_arbiter_ctrl #(.ADDR_W(32), .RAM_LAT(1)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (bus.ram_wr) mem[bus.ram_a[9:0]] <= bus.ram_dout;
        bus.ram_din <= mem[bus.ram_a[9:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        cyc();
        pl_en = 1'b0;
    endtask

    // Cycle index (0 = first cycle after the sampling edge) of the requested done pulse.
    task automatic wait_done(input bit want_ls, output int n);
        n = 99;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if ((want_ls ? bus.ls_done : bus.if_done) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Fetch at 0x100 and 1-byte load at 0x7 raised on the same edge.
    task automatic do_tie(input bit exp_ls_first);
        int  n;
        bit  first_ls;
        n = 99;
        first_ls = 1'b0;
        bus.if_addr = 32'h100; bus.if_re = 1'b1;
        bus.ls_addr = 32'h7;   bus.ls_len = 3'd1; bus.ls_re = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.ls_done === 1'b1 || bus.if_done === 1'b1) begin
                n = i;
                first_ls = bus.ls_done;
                break;
            end
        end
        chk1("tie_first_is_ls", first_ls, exp_ls_first);
        chk32("tie_first_cycle", n, exp_ls_first ? 32'd2 : 32'd5);
        if (first_ls) begin
            chk32("tie_ls_rdata", bus.ls_rdata, 32'h0000_0080);
            bus.ls_re = 1'b0;
        end else begin
            chk32("tie_if_rdata", bus.if_rdata, 32'h0010_0513);
            bus.if_re = 1'b0;
        end
        for (int i = n + 1; i < 20; i++) begin
            cyc();
            if ((first_ls ? bus.if_done : bus.ls_done) === 1'b1) begin
                n = i;
                break;
            end
            n = 99;
        end
        chk32("tie_second_cycle", n, 32'd9);
        if (first_ls) chk32("tie2_if_rdata", bus.if_rdata, 32'h0010_0513);
        else          chk32("tie2_ls_rdata", bus.ls_rdata, 32'h0000_0080);
        bus.if_re = 1'b0;
        bus.ls_re = 1'b0;
        last_ls_m = ~first_ls;
        cyc();
    endtask

    initial begin
        int n;
        bus.if_re = 1'b0; bus.if_addr = '0;
        bus.ls_re = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
        bus.ls_len = 3'd0; bus.ls_wdata = '0;

        // RAM contents while held in reset
        preload(10'h100, 8'h13); preload(10'h101, 8'h05);
        preload(10'h102, 8'h10); preload(10'h103, 8'h00);
        preload(10'h104, 8'hEE); preload(10'h007, 8'h80);
        preload(10'h020, 8'h00); preload(10'h021, 8'h00); preload(10'h022, 8'h5A);
        preload(10'h040, 8'h00); preload(10'h041, 8'h00);
        preload(10'h042, 8'h5A); preload(10'h043, 8'h5A);
        rst_in = 1'b0;
        cyc();

        chk1("rst_busy", bus.mc_busy, 1'b0);
        chk1("rst_ram_wr", bus.ram_wr, 1'b0);
        chk32("rst_ram_a", bus.ram_a, 32'h0);
        chk32("rst_ram_dout", {24'h0, bus.ram_dout}, 32'h0);
        chk1("rst_if_done", bus.if_done, 1'b0);
        chk1("rst_ls_done", bus.ls_done, 1'b0);
        chk32("rst_if_rdata", bus.if_rdata, 32'h0);
        chk32("rst_ls_rdata", bus.ls_rdata, 32'h0);

        // 4-byte fetch at 0x100
        bus.if_addr = 32'h100; bus.if_re = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k < 4) chk32($sformatf("fetch_ram_a_%0d", k), bus.ram_a, 32'h100 + 32'(k));
            chk1($sformatf("fetch_busy_%0d", k), bus.mc_busy, 1'b1);
            chk1($sformatf("fetch_done_%0d", k), bus.if_done, k == 5);
        end
        chk32("fetch_rdata", bus.if_rdata, 32'h0010_0513);
        bus.if_re = 1'b0;
        last_ls_m = 1'b0;
        cyc();
        chk1("fetch_idle_busy", bus.mc_busy, 1'b0);
        chk32("fetch_rdata_hold", bus.if_rdata, 32'h0010_0513);

        // 2-byte store at 0x20
        bus.ls_addr = 32'h20; bus.ls_len = 3'd2; bus.ls_wdata = 32'hAABB_CCDD; bus.ls_we = 1'b1;
        cyc();
        chk1("st_wr_0", bus.ram_wr, 1'b1);
        chk32("st_a_0", bus.ram_a, 32'h20);
        chk32("st_d_0", {24'h0, bus.ram_dout}, 32'hDD);
        cyc();
        chk1("st_wr_1", bus.ram_wr, 1'b1);
        chk32("st_a_1", bus.ram_a, 32'h21);
        chk32("st_d_1", {24'h0, bus.ram_dout}, 32'hCC);
        chk1("st_done_early", bus.ls_done, 1'b0);
        cyc();
        chk1("st_done", bus.ls_done, 1'b1);
        chk1("st_wr_off", bus.ram_wr, 1'b0);
        bus.ls_we = 1'b0;
        last_ls_m = 1'b1;
        cyc();
        chk32("st_mem20", {24'h0, mem[10'h020]}, 32'hDD);
        chk32("st_mem21", {24'h0, mem[10'h021]}, 32'hCC);
        chk32("st_mem22", {24'h0, mem[10'h022]}, 32'h5A);

        // 1-byte load at 0x7
        bus.ls_addr = 32'h7; bus.ls_len = 3'd1; bus.ls_re = 1'b1;
        wait_done(1'b1, n);
        chk32("ld1_cycle", n, 32'd2);
        chk32("ld1_rdata", bus.ls_rdata, 32'h0000_0080);
        bus.ls_re = 1'b0;
        cyc();

        // 3-byte load at 0x101: byte at 0x104 must not appear
        bus.ls_addr = 32'h101; bus.ls_len = 3'd3; bus.ls_re = 1'b1;
        wait_done(1'b1, n);
        chk32("ld3_cycle", n, 32'd4);
        chk32("ld3_rdata", bus.ls_rdata, 32'h0000_1005);
        bus.ls_re = 1'b0;
        cyc();

        // ls_len 0 behaves as a 4-byte load
        bus.ls_addr = 32'h101; bus.ls_len = 3'd0; bus.ls_re = 1'b1;
        wait_done(1'b1, n);
        chk32("ld0_cycle", n, 32'd5);
        chk32("ld0_rdata", bus.ls_rdata, 32'hEE00_1005);
        bus.ls_re = 1'b0;
        cyc();
        chk32("ls_hold_vs_fetch", bus.if_rdata, 32'h0010_0513);

        // Simultaneous requests, twice
        do_tie(RR ? ~last_ls_m : 1'b1);
        do_tie(RR ? ~last_ls_m : 1'b1);

        // rdy_in low for three cycles after the second read address
        bus.if_addr = 32'h100; bus.if_re = 1'b1;
        cyc();
        chk32("rdy_a_0", bus.ram_a, 32'h100);
        cyc();
        chk32("rdy_a_1", bus.ram_a, 32'h101);
        cyc();
        rdy_in = 1'b0;
        for (int k = 2; k < 5; k++) begin
            chk1($sformatf("rdy_low_done_%0d", k), bus.if_done, 1'b0);
            chk1($sformatf("rdy_low_busy_%0d", k), bus.mc_busy, 1'b1);
            chk32($sformatf("rdy_low_a_%0d", k), bus.ram_a, 32'h102);
            cyc();
        end
        rdy_in = 1'b1;
        chk1("rdy_resume_done", bus.if_done, 1'b0);
        for (int k = 6; k < 9; k++) begin
            cyc();
            chk32($sformatf("rdy_reissue_a_%0d", k), bus.ram_a, 32'h101 + 32'(k - 6));
        end
        cyc();
        chk1("rdy_done_c9", bus.if_done, 1'b0);
        cyc();
        chk1("rdy_done_c10", bus.if_done, 1'b1);
        chk32("rdy_rdata", bus.if_rdata, 32'h0010_0513);
        bus.if_re = 1'b0;
        cyc();

        // Reset during a 4-byte store, after two bytes
        bus.ls_addr = 32'h40; bus.ls_len = 3'd4; bus.ls_wdata = 32'h1122_3344; bus.ls_we = 1'b1;
        cyc();
        chk32("rst_wr_a_0", bus.ram_a, 32'h40);
        cyc();
        chk32("rst_wr_a_1", bus.ram_a, 32'h41);
        rst_in = 1'b1;
        bus.ls_we = 1'b0;
        cyc();
        chk1("rst_mid_wr", bus.ram_wr, 1'b0);
        chk1("rst_mid_busy", bus.mc_busy, 1'b0);
        chk1("rst_mid_done", bus.ls_done, 1'b0);
        chk32("rst_mid_if_rdata", bus.if_rdata, 32'h0);
        rst_in = 1'b0;
        cyc();
        chk1("rst_after_done", bus.ls_done, 1'b0);
        chk32("rst_mem40", {24'h0, mem[10'h040]}, 32'h44);
        chk32("rst_mem41", {24'h0, mem[10'h041]}, 32'h33);
        chk32("rst_mem42", {24'h0, mem[10'h042]}, 32'h5A);

        // Fetch after the aborted store
        bus.if_addr = 32'h100; bus.if_re = 1'b1;
        wait_done(1'b0, n);
        chk32("post_rst_fetch_cycle", n, 32'd5);
        chk32("post_rst_fetch_rdata", bus.if_rdata, 32'h0010_0513);
        bus.if_re = 1'b0;
        cyc();
        chk1("final_idle", bus.mc_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
